// File: rtl/ram_stream_fifo_if.sv
// Stream FIFO bus: write handshake, read handshake and occupancy status.
interface ram_stream_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) ();
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  almost_full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;

    // Producer/consumer side of the FIFO
    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, rd_data, rd_valid, empty, count
    );

    // FIFO side
    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, rd_data, rd_valid, empty, count
    );
endinterface

// File: rtl/ram_stream_fifo.sv
// Synchronous FIFO on an inferred RAM with a registered read port.
// The optional sticky overflow/underflow flags are built when the macro
// RAM_STREAM_FIFO_ERR_EN is defined.
module ram_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    ram_stream_fifo_if.slave bus
`ifdef RAM_STREAM_FIFO_ERR_EN
    ,
    output logic overflow,
    output logic underflow
`endif
);

    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status flags decoded straight from the occupancy register
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Accepts use start-of-cycle status; a flush swallows both requests
    assign wr_acc = bus.wr_en & ~full  & ~clear;
    assign rd_acc = bus.rd_en & ~empty & ~clear;

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (count >= CNT_W'(AF_THRESH));
    assign bus.count       = count;
    assign bus.rd_data     = rd_data;
    assign bus.rd_valid    = rd_valid;

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end
    end

    // Registered read port; rd_data survives a flush but not a reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

`ifdef RAM_STREAM_FIFO_ERR_EN
    // Sticky error flags for dropped requests
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.wr_en && full) begin
                overflow <= 1'b1;
            end
            if (bus.rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_stream_fifo.sv
// Directed bench for ram_stream_fifo with a four-entry configuration.
module tb_ram_stream_fifo;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;
    localparam int unsigned AF = 3;

    logic clk;
    logic rst;
    logic clear;
`ifdef RAM_STREAM_FIFO_ERR_EN
    logic overflow;
    logic underflow;
`endif

    int n_cmp;
    int n_err;

    ram_stream_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_stream_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_THRESH (AF)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .bus  (bus.slave)
`ifdef RAM_STREAM_FIFO_ERR_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input int cnt, input logic e,
                                input logic f, input logic af);
        check({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check({tag, ".empty"}, 32'(bus.empty), 32'(e));
        check({tag, ".full"},  32'(bus.full),  32'(f));
        check({tag, ".afull"}, 32'(bus.almost_full), 32'(af));
    endtask

    initial begin
        logic [7:0] wdata [4];
        logic [7:0] exp_rd;

        n_cmp = 0;
        n_err = 0;
        wdata[0] = 8'h11;
        wdata[1] = 8'h22;
        wdata[2] = 8'h33;
        wdata[3] = 8'h44;

        // Reset
        rst = 1'b1; clear = 1'b0;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_status("reset", 0, 1'b1, 1'b0, 1'b0);
        check("reset.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("reset.rd_data",  32'(bus.rd_data),  32'h00);
`ifdef RAM_STREAM_FIFO_ERR_EN
        check("reset.overflow",  32'(overflow),  32'd0);
        check("reset.underflow", 32'(underflow), 32'd0);
`endif

        // Fill with four writes
        bus.wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_data = wdata[i];
            step();
            check_status($sformatf("fill%0d", i), i + 1, 1'b0, (i == 3), (i >= 2));
        end

        // Write while full is dropped
        bus.wr_data = 8'h55;
        step();
        check_status("ovf", 4, 1'b0, 1'b1, 1'b1);
        bus.wr_en = 1'b0;
        step();
        check("ovf_hold.count", 32'(bus.count), 32'd4);
`ifdef RAM_STREAM_FIFO_ERR_EN
        check("ovf_hold.overflow", 32'(overflow), 32'd1);
`endif

        // Drain back to back
        bus.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("drain%0d.rd_valid", i), 32'(bus.rd_valid), 32'd1);
            check($sformatf("drain%0d.rd_data", i),  32'(bus.rd_data),  32'(wdata[i]));
            check_status($sformatf("drain%0d", i), 3 - i, (i == 3), 1'b0, (i == 0));
        end

        // Read while empty is dropped
        step();
        check("udf.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("udf.rd_data",  32'(bus.rd_data),  32'h44);
        check("udf.count",    32'(bus.count),    32'd0);
`ifdef RAM_STREAM_FIFO_ERR_EN
        check("udf.underflow", 32'(underflow), 32'd1);
        check("udf.overflow",  32'(overflow),  32'd1);
`endif
        bus.rd_en = 1'b0;

        // Prime to two entries
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA0;
        step();
        bus.wr_data = 8'hA1;
        step();
        check("prime.count", 32'(bus.count), 32'd2);

        // Steady state write+read; pointers wrap, order preserved
        bus.rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_data = 8'(8'hB0 + i);
            step();
            exp_rd = (i < 2) ? 8'(8'hA0 + i) : 8'(8'hB0 + i - 2);
            check($sformatf("steady%0d.count", i),    32'(bus.count),    32'd2);
            check($sformatf("steady%0d.rd_valid", i), 32'(bus.rd_valid), 32'd1);
            check($sformatf("steady%0d.rd_data", i),  32'(bus.rd_data),  32'(exp_rd));
        end
        bus.rd_en = 1'b0;

        // Raise to three entries
        bus.wr_data = 8'hC0;
        step();
        bus.wr_en = 1'b0;
        check_status("pre_clr", 3, 1'b0, 1'b0, 1'b1);

        // Flush with colliding write and read requests
        clear = 1'b1;
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.wr_data = 8'h77;
        step();
        clear = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check_status("clr", 0, 1'b1, 1'b0, 1'b0);
        check("clr.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("clr.rd_data",  32'(bus.rd_data),  32'hB7);
`ifdef RAM_STREAM_FIFO_ERR_EN
        check("clr.overflow",  32'(overflow),  32'd0);
        check("clr.underflow", 32'(underflow), 32'd0);
`endif

        // Round trip after flush
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        step();
        bus.wr_en = 1'b0;
        check("post_wr.count", 32'(bus.count), 32'd1);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("post_rd.rd_valid", 32'(bus.rd_valid), 32'd1);
        check("post_rd.rd_data",  32'(bus.rd_data),  32'hA5);
        check("post_rd.empty",    32'(bus.empty),    32'd1);
        step();
        check("idle.rd_valid", 32'(bus.rd_valid), 32'd0);
        check("idle.rd_data",  32'(bus.rd_data),  32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
